hazard_scoreboard: RTL and testbench

Parametrised hazard unit for the 5-stage RISC-V core. It replaces the purely combinational load-use/ECALL check with a per-register pending-write scoreboard for variable-latency units such as multi-cycle MUL/DIV or a miss-capable data cache. It sits beside the ID stage and drives the PC/IF-ID stall. It also tracks outstanding long-latency operations, enforces an outstanding-op limit, reports the stall cause, and counts stall cycles.

---
 rtl/hazard_scoreboard_pkg.sv | 20 ++
 rtl/hazard_scoreboard_if.sv | 45 ++++
 rtl/hazard_sb_regs.sv | 37 +++
 rtl/hazard_scoreboard.sv | 98 +++++++++
 tb/tb_hazard_scoreboard.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard unit: stall-cause encodings,
// default ECALL source register and the base opcodes the decoder keys on.
package hazard_scoreboard_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // a7 carries the syscall number read by ECALL
  localparam int unsigned ECALL_REG_DEFAULT = 17;

  typedef enum logic [1:0] {
    HZ_NONE   = 2'b00,
    HZ_EX     = 2'b01,
    HZ_SB     = 2'b10,
    HZ_STRUCT = 2'b11
  } hz_cause_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Bundle between the pipeline (ID/EX/long-latency writeback) and the hazard unit.
interface hazard_scoreboard_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned OUT_W = 3,
  parameter int unsigned CNT_W = 32
);
  import hazard_scoreboard_pkg::*;

  logic             id_valid;
  logic             id_flush;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_long;
  logic             id_is_ecall;
  logic [REG_W-1:0] ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             lu_done;
  logic [REG_W-1:0] lu_rd;

  logic             stall;
  hz_cause_e        stall_cause;
  logic [OUT_W-1:0] outstanding;
  logic [CNT_W-1:0] stall_cycles;
  logic             sb_err;

  modport master (
    output id_valid, id_flush, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_long, id_is_ecall,
           ex_rd, ex_reg_write, ex_mem_read, lu_done, lu_rd,
    input  stall, stall_cause, outstanding, stall_cycles, sb_err
  );

  modport slave (
    input  id_valid, id_flush, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_long, id_is_ecall,
           ex_rd, ex_reg_write, ex_mem_read, lu_done, lu_rd,
    output stall, stall_cause, outstanding, stall_cycles, sb_err
  );

endinterface

// File: rtl/hazard_sb_regs.sv
// Per-register pending-write bits with issue-set, completion-clear and the
// completion-cycle bypass view used by the hazard checks.
module hazard_sb_regs #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_W    = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                issue,
  input  logic [REG_W-1:0]    issue_rd,
  input  logic                lu_done,
  input  logic [REG_W-1:0]    lu_rd,
  output logic [NUM_REGS-1:0] pend_eff,
  output logic                done_valid
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_nxt;

  // Bit 0 is never written, so x0 reads as not pending everywhere
  always_comb begin
    done_valid = lu_done & pend_q[lu_rd];
    pend_eff   = pend_q;
    if (lu_done) pend_eff[lu_rd] = 1'b0;
    pend_nxt = pend_q;
    if (done_valid) pend_nxt[lu_rd] = 1'b0;
    // set after clear: same-register issue and completion stays pending
    if (issue) pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pend_q <= '0;
    else          pend_q <= pend_nxt;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: EX load-use/ECALL checks, pending-write scoreboard
// for long-latency units, outstanding-op limit and stall statistics.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned MAX_OUT   = 4,
  parameter int unsigned ECALL_REG = ECALL_REG_DEFAULT,
  parameter int unsigned CNT_W     = 32
) (
  input logic          clk,
  input logic          reset_n,
  hazard_scoreboard_if.slave hz
);

  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

  logic [NUM_REGS-1:0] pend_eff;
  logic                done_valid;
  logic                gate;
  logic                ex_hz;
  logic                sb_hz;
  logic                st_hz;
  logic                stall_raw;
  logic                issue;
  hz_cause_e           cause;
  logic [OUT_W-1:0]    out_q;
  logic [OUT_W-1:0]    out_nxt;
  logic [CNT_W-1:0]    cyc_q;
  logic [CNT_W-1:0]    cyc_nxt;
  logic                err_q;

  hazard_sb_regs #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W)
  ) u_regs (
    .clk        (clk),
    .reset_n    (reset_n),
    .issue      (issue),
    .issue_rd   (hz.id_rd),
    .lu_done    (hz.lu_done),
    .lu_rd      (hz.lu_rd),
    .pend_eff   (pend_eff),
    .done_valid (done_valid)
  );

  // Hazard terms, priority encode and issue decision
  always_comb begin
    gate  = hz.id_valid & ~hz.id_flush;
    ex_hz = gate & (
              (hz.ex_mem_read & (hz.ex_rd != '0) &
               ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)))) |
              (hz.id_is_ecall & hz.ex_reg_write & (hz.ex_rd == REG_W'(ECALL_REG))));
    sb_hz = gate & (
              (hz.id_use_rs1 & pend_eff[hz.id_rs1]) |
              (hz.id_use_rs2 & pend_eff[hz.id_rs2]) |
              (hz.id_reg_write & (hz.id_rd != '0) & pend_eff[hz.id_rd]) |
              (hz.id_is_ecall & pend_eff[REG_W'(ECALL_REG)]));
    st_hz = gate & hz.id_long & (out_q == OUT_W'(MAX_OUT)) & ~done_valid;
    stall_raw = ex_hz | sb_hz | st_hz;
    cause = HZ_NONE;
    if (ex_hz)      cause = HZ_EX;
    else if (sb_hz) cause = HZ_SB;
    else if (st_hz) cause = HZ_STRUCT;
    issue = gate & ~stall_raw & hz.id_long & hz.id_reg_write & (hz.id_rd != '0);
  end

  // Counter next-state; issue and completion together cancel out
  always_comb begin
    out_nxt = out_q;
    if (issue && !done_valid && out_q != OUT_W'(MAX_OUT)) out_nxt = out_q + OUT_W'(1);
    else if (!issue && done_valid && out_q != '0)         out_nxt = out_q - OUT_W'(1);
    cyc_nxt = cyc_q;
    if (stall_raw && cyc_q != '1) cyc_nxt = cyc_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
      cyc_q <= '0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_nxt;
      cyc_q <= cyc_nxt;
      if (hz.lu_done && !done_valid) err_q <= 1'b1;
    end
  end

  // Combinational outputs are forced quiet while reset is held
  assign hz.stall        = reset_n & stall_raw;
  assign hz.stall_cause  = reset_n ? cause : HZ_NONE;
  assign hz.outstanding  = out_q;
  assign hz.stall_cycles = cyc_q;
  assign hz.sb_err       = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, reset corner cases and
// randomized traffic against an in-flight-list reference model.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned MAX_OUT   = 2;
  localparam int unsigned ECALL_REG = 17;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned OUT_W     = $clog2(MAX_OUT + 1);
  localparam int          CYC_MAX   = (1 << CNT_W) - 1;

  typedef struct {
    bit v, fl;
    int rs1, rs2;
    bit u1, u2;
    int rd;
    bit rw, lg, ec;
    int exrd;
    bit exw, exm, dn;
    int lrd;
  } stim_t;

  typedef struct {
    stim_t s;
    bit    stall;
    int    cause;
    int    outs;
    bit    err;
    int    cyc;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_W(REG_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) hz ();

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W),
    .MAX_OUT  (MAX_OUT),
    .ECALL_REG(ECALL_REG),
    .CNT_W    (CNT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .hz     (hz)
  );

  int n_cmp = 0;
  int n_fail = 0;
  vec_t tbl[$];

  // reference model state: list of registers with an op in flight
  int m_q[$];
  bit m_err;
  int m_cyc;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(bit v, bit fl, int rs1, int rs2, bit u1, bit u2, int rd,
                               bit rw, bit lg, bit ec, int exrd, bit exw, bit exm,
                               bit dn, int lrd);
    stim_t s;
    s.v = v; s.fl = fl; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
    s.rd = rd; s.rw = rw; s.lg = lg; s.ec = ec; s.exrd = exrd; s.exw = exw;
    s.exm = exm; s.dn = dn; s.lrd = lrd;
    return s;
  endfunction

  function automatic stim_t idle_done(int lrd);
    return mk(0,0,0,0,0,0,0,0,0,0, 0,0,0, 1,lrd);
  endfunction

  function automatic stim_t long_op(int rd, bit dn, int lrd);
    return mk(1,0,1,2,1,1,rd,1,1,0, 0,0,0, dn,lrd);
  endfunction

  task automatic add(input stim_t s, input bit st, input int c, input int o,
                     input bit e, input int cy);
    vec_t t;
    t.s = s; t.stall = st; t.cause = c; t.outs = o; t.err = e; t.cyc = cy;
    tbl.push_back(t);
  endtask

  task automatic apply(input stim_t s);
    hz.id_valid     = s.v;
    hz.id_flush     = s.fl;
    hz.id_rs1       = REG_W'(s.rs1);
    hz.id_rs2       = REG_W'(s.rs2);
    hz.id_use_rs1   = s.u1;
    hz.id_use_rs2   = s.u2;
    hz.id_rd        = REG_W'(s.rd);
    hz.id_reg_write = s.rw;
    hz.id_long      = s.lg;
    hz.id_is_ecall  = s.ec;
    hz.ex_rd        = REG_W'(s.exrd);
    hz.ex_reg_write = s.exw;
    hz.ex_mem_read  = s.exm;
    hz.lu_done      = s.dn;
    hz.lu_rd        = REG_W'(s.lrd);
  endtask

  // one cycle: combinational check mid-cycle, state check just after the edge
  task automatic run_vec(input string tag, input stim_t s, input bit est, input int ec,
                         input int eo, input bit ee, input int ecy);
    apply(s);
    @(negedge clk);
    chk({tag, ".stall"}, int'(hz.stall), int'(est));
    chk({tag, ".cause"}, int'(hz.stall_cause), ec);
    @(posedge clk);
    #1;
    chk({tag, ".outstanding"}, int'(hz.outstanding), eo);
    chk({tag, ".sb_err"}, int'(hz.sb_err), int'(ee));
    chk({tag, ".stall_cycles"}, int'(hz.stall_cycles), ecy);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".stall"}, int'(hz.stall), 0);
    chk({tag, ".cause"}, int'(hz.stall_cause), 0);
    chk({tag, ".outstanding"}, int'(hz.outstanding), 0);
    chk({tag, ".sb_err"}, int'(hz.sb_err), 0);
    chk({tag, ".stall_cycles"}, int'(hz.stall_cycles), 0);
  endtask

  // async reset asserted mid-cycle; outputs must clear before any edge
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk_zero(tag);
    apply(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0, 0,0));
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    m_q.delete();
    m_err = 1'b0;
    m_cyc = 0;
  endtask

  function automatic bit in_flight(int r);
    foreach (m_q[i]) if (m_q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: evaluate the cycle's hazards from the rules, then advance state
  task automatic model_step(input stim_t s, output bit st, output int cause);
    bit g, exh, sbh, sth, ok, iss;
    bit pe1, pe2, per, pee;
    g   = s.v && !s.fl;
    ok  = s.dn && s.lrd != 0 && in_flight(s.lrd);
    pe1 = s.rs1 != 0 && in_flight(s.rs1) && !(s.dn && s.lrd == s.rs1);
    pe2 = s.rs2 != 0 && in_flight(s.rs2) && !(s.dn && s.lrd == s.rs2);
    per = s.rd  != 0 && in_flight(s.rd)  && !(s.dn && s.lrd == s.rd);
    pee = in_flight(ECALL_REG) && !(s.dn && s.lrd == ECALL_REG);
    exh = g && ((s.exm && s.exrd != 0 && ((s.u1 && s.rs1 == s.exrd) || (s.u2 && s.rs2 == s.exrd)))
                || (s.ec && s.exw && s.exrd == ECALL_REG));
    sbh = g && ((s.u1 && pe1) || (s.u2 && pe2) || (s.rw && per) || (s.ec && pee));
    sth = g && s.lg && m_q.size() == MAX_OUT && !ok;
    st  = exh || sbh || sth;
    cause = exh ? 1 : sbh ? 2 : sth ? 3 : 0;
    iss = g && !st && s.lg && s.rw && s.rd != 0;
    if (ok) begin
      for (int i = 0; i < m_q.size(); i++)
        if (m_q[i] == s.lrd) begin m_q.delete(i); break; end
    end
    if (iss) m_q.push_back(s.rd);
    if (s.dn && !ok) m_err = 1'b1;
    if (st && m_cyc < CYC_MAX) m_cyc++;
  endtask

  function automatic int rreg();
    return ($urandom_range(0, 7) == 0) ? int'(ECALL_REG) : int'($urandom_range(0, 7));
  endfunction

  initial begin
    stim_t s;
    bit    st;
    int    ca;

    apply(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0, 0,0));
    do_reset("reset");

    //    v fl rs1 rs2 u1 u2 rd rw lg ec  exrd exw exm  dn lrd        stall cause out err cyc
    add(mk(1,0, 5, 1, 1, 1, 6, 1, 0, 0,  5, 1, 1,  0, 0),           1, 1, 0, 0, 1);
    add(mk(1,0, 5, 1, 1, 1, 6, 1, 0, 0,  0, 0, 0,  0, 0),           0, 0, 0, 0, 1);
    add(mk(1,1, 5, 1, 1, 1, 6, 1, 0, 0,  5, 1, 1,  0, 0),           0, 0, 0, 0, 1);
    add(mk(0,0, 5, 1, 1, 1, 6, 1, 0, 0,  5, 1, 1,  0, 0),           0, 0, 0, 0, 1);
    add(mk(1,0, 0, 1, 1, 1, 6, 1, 0, 0,  0, 1, 1,  0, 0),           0, 0, 0, 0, 1);
    add(long_op(7, 0, 0),                                          0, 0, 1, 0, 1);
    add(mk(1,0, 7, 1, 1, 1, 8, 1, 0, 0,  0, 0, 0,  0, 0),           1, 2, 1, 0, 2);
    add(mk(1,0, 7, 1, 1, 1, 8, 1, 0, 0,  0, 0, 0,  0, 0),           1, 2, 1, 0, 3);
    add(mk(1,0, 7, 1, 1, 1, 8, 1, 0, 0,  0, 0, 0,  1, 7),           0, 0, 0, 0, 3);
    add(long_op(8, 0, 0),                                          0, 0, 1, 0, 3);
    add(long_op(9, 0, 0),                                          0, 0, 2, 0, 3);
    add(long_op(10, 0, 0),                                         1, 3, 2, 0, 4);
    add(long_op(10, 1, 8),                                         0, 0, 2, 0, 4);
    add(mk(1,0, 0, 0, 0, 0, 0, 0, 0, 1, 17, 1, 0,  0, 0),           1, 1, 2, 0, 5);
    add(idle_done(9),                                              0, 0, 1, 0, 5);
    add(long_op(17, 0, 0),                                         0, 0, 2, 0, 5);
    add(mk(1,0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0),           1, 2, 2, 0, 6);
    add(mk(1,0, 0, 0, 0, 0, 0, 0, 0, 1, 17, 1, 0,  0, 0),           1, 1, 2, 0, 7);
    add(mk(1,0, 0, 0, 1, 0,10, 1, 0, 0,  0, 0, 0,  0, 0),           1, 2, 2, 0, 8);
    add(idle_done(10),                                             0, 0, 1, 0, 8);
    add(idle_done(17),                                             0, 0, 0, 0, 8);
    add(long_op(0, 0, 0),                                          0, 0, 0, 0, 8);
    add(mk(1,1, 1, 2, 1, 1, 5, 1, 1, 0,  0, 0, 0,  0, 0),           0, 0, 0, 0, 8);
    add(mk(1,0, 5, 0, 1, 0, 6, 1, 0, 0,  0, 0, 0,  0, 0),           0, 0, 0, 0, 8);
    add(long_op(4, 0, 0),                                          0, 0, 1, 0, 8);
    add(long_op(4, 1, 4),                                          0, 0, 1, 0, 8);
    add(mk(1,0, 4, 0, 1, 0, 6, 1, 0, 0,  0, 0, 0,  0, 0),           1, 2, 1, 0, 9);
    add(idle_done(4),                                              0, 0, 0, 0, 9);
    add(idle_done(3),                                              0, 0, 0, 1, 9);
    add(idle_done(0),                                              0, 0, 0, 1, 9);

    foreach (tbl[i])
      run_vec($sformatf("vec%0d", i), tbl[i].s, tbl[i].stall, tbl[i].cause,
              tbl[i].outs, tbl[i].err, tbl[i].cyc);

    // Reset pulled while stalled on a pending long op
    run_vec("mid.issue", long_op(11, 0, 0), 0, 0, 1, 1, 9);
    apply(mk(1,0,11, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("mid.stall_before", int'(hz.stall), 1);
    #1 reset_n = 1'b0;
    #1 chk_zero("mid.async");
    apply(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0, 0,0));
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_vec("mid.stale_done", idle_done(11), 0, 0, 0, 1, 0);

    // Randomized traffic against the reference model
    do_reset("rnd.reset0");
    for (int n = 0; n < 2000; n++) begin
      if (n > 0 && n % 250 == 0) do_reset($sformatf("rnd.reset%0d", n));
      s = mk($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, rreg(), rreg(),
             $urandom_range(0, 1), $urandom_range(0, 1), rreg(), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, rreg(),
             $urandom_range(0, 1), $urandom_range(0, 3) == 0, 1'b0, 0);
      if (m_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        s.dn  = 1'b1;
        s.lrd = m_q[$urandom_range(0, m_q.size() - 1)];
      end else if ($urandom_range(0, 19) == 0) begin
        s.dn  = 1'b1;
        s.lrd = rreg();
      end
      model_step(s, st, ca);
      run_vec($sformatf("rnd%0d", n), s, st, ca, m_q.size(), m_err, m_cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
